// File: rtl/acs_stage_scheduler_pkg.sv
// Shared constants for the ACS stage scheduler: default sizes, metric address
// width and the scheduler FSM encoding.
package acs_stage_scheduler_pkg;

    localparam int NUM_STATES_DEF  = 16;
    localparam int SETUP_WORDS_DEF = 32;
    localparam int MADDR_W         = 4;
    localparam int BCNT_W          = 7;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETUP     = 3'd1;
    localparam logic [2:0] ST_READY     = 3'd2;
    localparam logic [2:0] ST_FEED      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    function automatic int setup_total(input int stages, input int words);
        return stages * words;
    endfunction

endpackage

// File: rtl/metric_feed_counter.sv
// Generates the accumulated-metric feed window: en high for NUM_STATES cycles
// after a start pulse while addr steps from 0; clear aborts the window.
module metric_feed_counter
    import acs_stage_scheduler_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic               clear,
    output logic               en,
    output logic [MADDR_W-1:0] addr,
    output logic               last
);

    localparam logic [MADDR_W-1:0] LAST_ADDR = MADDR_W'(NUM_STATES - 1);

    logic               en_q;
    logic               en_d;
    logic [MADDR_W-1:0] addr_q;
    logic [MADDR_W-1:0] addr_d;

    assign last = en_q && (addr_q == LAST_ADDR);

    // Address returns to 0 whenever the window is closed.
    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        if (clear) begin
            en_d   = 1'b0;
            addr_d = '0;
        end else if (start) begin
            en_d   = 1'b1;
            addr_d = '0;
        end else if (en_q) begin
            if (last) begin
                en_d   = 1'b0;
                addr_d = '0;
            end else begin
                addr_d = addr_q + MADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            en_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
        end
    end

    assign en   = en_q;
    assign addr = addr_q;

endmodule

// File: rtl/acs_stage_scheduler.sv
// Frame/block scheduler for a chain of ACS stages: loads setup tables, launches
// blocks, drives the metric feed window and counts completed blocks per frame.
module acs_stage_scheduler
    import acs_stage_scheduler_pkg::*;
#(
    parameter int NUM_STAGES       = 2,
    parameter int SETUP_WORDS      = SETUP_WORDS_DEF,
    parameter int NUM_STATES       = NUM_STATES_DEF,
    parameter int BLOCKS_PER_FRAME = 64
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               clkEn,
    input  logic               frameIn,
    input  logic               blockIn,
    input  logic               setupValid,
    input  logic               lastStageDone,
    output logic               startFrame,
    output logic               startBlock,
    output logic               startStage,
    output logic               setupComplete,
    output logic               metricEn,
    output logic [MADDR_W-1:0] metricRdAddr,
    output logic [BCNT_W-1:0]  blockCount,
    output logic               frameDone,
    output logic               overrun
);

    localparam int SETUP_TOTAL = setup_total(NUM_STAGES, SETUP_WORDS);
    localparam int SCNT_W      = $clog2(SETUP_TOTAL) + 1;

    logic [2:0]        state_q,          state_d;
    logic [SCNT_W-1:0] setup_cnt_q,      setup_cnt_d;
    logic [BCNT_W-1:0] block_cnt_q,      block_cnt_d;
    logic              setup_complete_q, setup_complete_d;
    logic              overrun_q,        overrun_d;
    logic              start_frame_q,    start_frame_d;
    logic              start_block_q,    start_block_d;
    logic              start_stage_q;
    logic              frame_done_q,     frame_done_d;

    logic frame_go;
    logic block_go;
    logic feed_last;

    assign frame_go = clkEn && frameIn;
    assign block_go = clkEn && blockIn;

    always_comb begin
        state_d          = state_q;
        setup_cnt_d      = setup_cnt_q;
        block_cnt_d      = block_cnt_q;
        setup_complete_d = setup_complete_q;
        overrun_d        = overrun_q;
        start_frame_d    = 1'b0;
        start_block_d    = 1'b0;
        frame_done_d     = 1'b0;

        // A frame start wins over everything, including a block in flight.
        if (frame_go) begin
            start_frame_d    = 1'b1;
            setup_cnt_d      = '0;
            block_cnt_d      = '0;
            setup_complete_d = 1'b0;
            state_d          = ST_SETUP;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    if (block_go) overrun_d = 1'b1;
                    if (setupValid) begin
                        setup_cnt_d = setup_cnt_q + SCNT_W'(1);
                        if (setup_cnt_d == SCNT_W'(SETUP_TOTAL)) begin
                            state_d          = ST_READY;
                            setup_complete_d = 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (block_go) begin
                        start_block_d = 1'b1;
                        state_d       = ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (block_go) overrun_d = 1'b1;
                    if (feed_last) state_d = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (lastStageDone) begin
                        block_cnt_d = block_cnt_q + BCNT_W'(1);
                        if (block_cnt_d == BCNT_W'(BLOCKS_PER_FRAME)) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else if (block_go) begin
                            start_block_d = 1'b1;
                            state_d       = ST_FEED;
                        end else begin
                            state_d = ST_READY;
                        end
                    end else if (block_go) begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q          <= ST_IDLE;
            setup_cnt_q      <= '0;
            block_cnt_q      <= '0;
            setup_complete_q <= 1'b0;
            overrun_q        <= 1'b0;
            start_frame_q    <= 1'b0;
            start_block_q    <= 1'b0;
            start_stage_q    <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            setup_cnt_q      <= setup_cnt_d;
            block_cnt_q      <= block_cnt_d;
            setup_complete_q <= setup_complete_d;
            overrun_q        <= overrun_d;
            start_frame_q    <= start_frame_d;
            start_block_q    <= start_block_d;
            start_stage_q    <= start_block_d;
            frame_done_q     <= frame_done_d;
        end
    end

    // The feed window opens on the cycle after startStage is seen.
    metric_feed_counter #(
        .NUM_STATES(NUM_STATES)
    ) u_feed (
        .clk   (clk),
        .resetN(resetN),
        .start (start_stage_q),
        .clear (frame_go),
        .en    (metricEn),
        .addr  (metricRdAddr),
        .last  (feed_last)
    );

    assign startFrame    = start_frame_q;
    assign startBlock    = start_block_q;
    assign startStage    = start_stage_q;
    assign setupComplete = setup_complete_q;
    assign blockCount    = block_cnt_q;
    assign frameDone     = frame_done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_acs_stage_scheduler.sv
// Directed-plus-random bench for acs_stage_scheduler; expected outputs come
// from a timeline model of frames, setup loads and block feeds.
module tb_acs_stage_scheduler;

    localparam int TOTAL_SETUP = 64;
    localparam int NSTATES     = 16;
    localparam int NBLOCKS     = 64;

    logic       clk = 1'b0;
    logic       resetN, clkEn, frameIn, blockIn, setupValid, lastStageDone;
    logic       startFrame, startBlock, startStage, setupComplete, metricEn;
    logic [3:0] metricRdAddr;
    logic [6:0] blockCount;
    logic       frameDone, overrun;

    int n_cmp = 0;
    int n_mis = 0;

    // expected output values for the edge about to be checked
    int e_sf = 0, e_sb = 0, e_me = 0, e_addr = 0, e_fd = 0;
    int e_bc = 0, e_ov = 0, e_sc = 0;

    always #5 clk = ~clk;

    acs_stage_scheduler #(
        .NUM_STAGES      (2),
        .SETUP_WORDS     (32),
        .NUM_STATES      (NSTATES),
        .BLOCKS_PER_FRAME(NBLOCKS)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .clkEn        (clkEn),
        .frameIn      (frameIn),
        .blockIn      (blockIn),
        .setupValid   (setupValid),
        .lastStageDone(lastStageDone),
        .startFrame   (startFrame),
        .startBlock   (startBlock),
        .startStage   (startStage),
        .setupComplete(setupComplete),
        .metricEn     (metricEn),
        .metricRdAddr (metricRdAddr),
        .blockCount   (blockCount),
        .frameDone    (frameDone),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, check every output, then clear the pulse expectations.
    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".startFrame"},    startFrame,    e_sf);
        chk({tag, ".startBlock"},    startBlock,    e_sb);
        chk({tag, ".startStage"},    startStage,    e_sb);
        chk({tag, ".setupComplete"}, setupComplete, e_sc);
        chk({tag, ".metricEn"},      metricEn,      e_me);
        chk({tag, ".metricRdAddr"},  metricRdAddr,  e_addr);
        chk({tag, ".blockCount"},    blockCount,    e_bc);
        chk({tag, ".frameDone"},     frameDone,     e_fd);
        chk({tag, ".overrun"},       overrun,       e_ov);
        e_sf = 0; e_sb = 0; e_me = 0; e_addr = 0; e_fd = 0;
    endtask

    // Random inputs that must have no effect: strobes only while clkEn is low.
    task automatic idle_inputs();
        clkEn         = 1'($urandom_range(0, 1));
        frameIn       = !clkEn && ($urandom_range(0, 1) == 1);
        blockIn       = !clkEn && ($urandom_range(0, 1) == 1);
        setupValid    = 1'($urandom_range(0, 1));
        lastStageDone = 1'($urandom_range(0, 1));
    endtask

    task automatic do_frame(input string tag);
        idle_inputs();
        clkEn = 1'b1; frameIn = 1'b1; blockIn = 1'b0;
        e_sf = 1; e_bc = 0; e_sc = 0;
        cycle(tag);
        $display("frame start: %s", tag);
    endtask

    task automatic do_setup(input int inject_at);
        for (int k = 1; k <= TOTAL_SETUP; k++) begin
            repeat ($urandom_range(0, 2)) begin
                idle_inputs();
                setupValid = 1'b0;
                cycle("setup_gap");
            end
            idle_inputs();
            setupValid = 1'b1;
            if (k == inject_at) begin
                clkEn = 1'b1; frameIn = 1'b0; blockIn = 1'b1; e_ov = 1;
            end
            if (k == TOTAL_SETUP) e_sc = 1;
            cycle(k == TOTAL_SETUP - 1 ? "setup63" : (k == TOTAL_SETUP ? "setup64" : "setup"));
        end
        $display("setup loaded: %0d words", TOTAL_SETUP);
    endtask

    task automatic start_block(input string tag);
        idle_inputs();
        clkEn = 1'b1; frameIn = 1'b0; blockIn = 1'b1;
        e_sb = 1;
        cycle(tag);
    endtask

    // n feed ticks; a complete window is followed by the tick entering WAIT_DONE.
    task automatic run_feed(input int inject_at, input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            if (i == inject_at) begin
                clkEn = 1'b1; frameIn = 1'b0; blockIn = 1'b1; e_ov = 1;
            end
            e_me = 1; e_addr = i;
            cycle("feed");
        end
        if (n == NSTATES) begin
            idle_inputs();
            cycle("feed_end");
        end
    endtask

    task automatic finish_block(input bit chain);
        repeat ($urandom_range(0, 2)) begin
            idle_inputs();
            lastStageDone = 1'b0;
            cycle("wait");
        end
        idle_inputs();
        lastStageDone = 1'b1;
        e_bc++;
        if (e_bc == NBLOCKS) begin
            e_fd = 1;
        end else if (chain) begin
            clkEn = 1'b1; frameIn = 1'b0; blockIn = 1'b1; e_sb = 1;
        end
        cycle("done");
    endtask

    initial begin
        bit chain;
        bit need_start;
        int ov_block;
        int ov_idx;

        resetN = 1'b0; clkEn = 1'b0; frameIn = 1'b0; blockIn = 1'b0;
        setupValid = 1'b0; lastStageDone = 1'b0;
        cycle("reset");
        cycle("reset");
        resetN = 1'b1;
        idle_inputs();
        cycle("idle");

        // Frame 1: full load, 64 blocks, one overrun during a feed window.
        do_frame("frame1");
        do_setup(0);
        ov_block   = $urandom_range(0, NBLOCKS - 1);
        ov_idx     = $urandom_range(0, NSTATES - 1);
        need_start = 1'b1;
        for (int b = 0; b < NBLOCKS; b++) begin
            if (need_start) begin
                repeat ($urandom_range(0, 3)) begin
                    idle_inputs();
                    cycle("ready");
                end
                start_block("start");
            end
            run_feed(b == ov_block ? ov_idx : -1, NSTATES);
            chain = (b < NBLOCKS - 1) && ($urandom_range(0, 3) == 0);
            finish_block(chain);
            need_start = !chain;
            $display("block %0d complete, chained=%0d, blockCount=%0d", b, chain, blockCount);
        end
        idle_inputs();
        clkEn = 1'b1; frameIn = 1'b0; blockIn = 1'b1;
        cycle("idle_block");

        // Reset overrides a qualified frame strobe and clears sticky state.
        idle_inputs();
        resetN = 1'b0; clkEn = 1'b1; frameIn = 1'b1;
        e_bc = 0; e_ov = 0; e_sc = 0;
        cycle("reset_frame");
        resetN = 1'b1;
        idle_inputs();
        cycle("post_reset");

        // Frame 2: overrun in SETUP, one block, then abort mid-feed.
        do_frame("frame2");
        do_setup($urandom_range(1, TOTAL_SETUP));
        start_block("start2");
        run_feed(-1, NSTATES);
        finish_block(1'b0);
        start_block("start2b");
        run_feed(-1, 8);
        do_frame("abort");
        do_setup(0);

        // Reset in WAIT_DONE with lastStageDone high.
        start_block("start3");
        run_feed(-1, NSTATES);
        idle_inputs();
        resetN = 1'b0; lastStageDone = 1'b1;
        e_bc = 0; e_ov = 0; e_sc = 0;
        cycle("reset_wait");
        resetN = 1'b1;

        // Frame 3: blockIn in WAIT_DONE is dropped, the next block still starts.
        do_frame("frame3");
        do_setup(0);
        start_block("start4");
        run_feed(-1, NSTATES);
        idle_inputs();
        clkEn = 1'b1; frameIn = 1'b0; blockIn = 1'b1; lastStageDone = 1'b0;
        e_ov = 1;
        cycle("wait_overrun");
        finish_block(1'b0);
        start_block("restart");
        run_feed(-1, NSTATES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/acs_stage_scheduler.md
ACS_STAGE_SCHEDULER -- requirements
Module: acs_stage_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_STAGES, 2, ACS stages chained per block.
- SETUP_WORDS, 32, setup table entries per stage.
- NUM_STATES, 16, trellis states fed per block.
- BLOCKS_PER_FRAME, 64, blocks per frame.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- resetN, in, 1, synchronous active-low reset.
- clkEn, in, 1, sample-rate enable.
- frameIn, in, 1, frame-start strobe; qualified by clkEn.
- blockIn, in, 1, block-start strobe; qualified by clkEn.
- setupValid, in, 1, one setup table write.
- lastStageDone, in, 1, final-stage metric-out completion pulse.
- startFrame, out, 1, frame-start pulse to the ACS stages.
- startBlock, out, 1, block-start pulse to the ACS stages.
- startStage, out, 1, stage-1 start pulse.
- setupComplete, out, 1, level; all tables loaded.
- metricEn, out, 1, accumulated-metric feed enable.
- metricRdAddr, out, 4, metric memory read address.
- blockCount, out, 7, blocks completed in the current frame.
- frameDone, out, 1, one-cycle pulse.
- overrun, out, 1, sticky error flag.

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, READY, FEED and WAIT_DONE.
REQ-004 In any state, clkEn&&frameIn SHALL pulse startFrame for 1 cycle, clear the setup counter and blockCount, and enter SETUP on the next cycle. This rule has priority over all other transitions, including an abort mid-block.
REQ-005 In SETUP, each setupValid SHALL increment a counter of width clog2(NUM_STAGES*SETUP_WORDS)+1.
REQ-006 When the counter reaches NUM_STAGES*SETUP_WORDS, the FSM SHALL enter READY and setupComplete SHALL assert on that cycle and hold until the next frame start or reset.
REQ-007 setupValid outside SETUP SHALL be ignored.
REQ-008 In READY, clkEn&&blockIn SHALL pulse startBlock and startStage together in the next cycle and enter FEED.
REQ-009 In FEED, metricEn SHALL be high for exactly NUM_STATES consecutive cycles, beginning the cycle after startStage. During those cycles metricRdAddr SHALL step 0..15; the FSM then enters WAIT_DONE.
REQ-010 metricRdAddr SHALL be 0 whenever metricEn is low.
REQ-011 In WAIT_DONE, lastStageDone SHALL increment blockCount.
REQ-012 On lastStageDone in WAIT_DONE, if blockCount then equals BLOCKS_PER_FRAME, the block SHALL pulse frameDone and enter IDLE; otherwise it SHALL enter READY.
REQ-013 lastStageDone and clkEn&&blockIn in the same cycle in WAIT_DONE SHALL complete the current block and start the next block; the next block's startBlock follows one cycle later.
REQ-014 clkEn&&blockIn in SETUP, FEED or WAIT_DONE (other than per REQ-013) SHALL set overrun, and the block SHALL be dropped.
REQ-015 overrun SHALL clear only on reset.
REQ-016 lastStageDone outside WAIT_DONE SHALL be ignored.
REQ-017 clkEn low SHALL stall nothing except the qualification of frameIn and blockIn.

Reset
REQ-018 While resetN is low at a clk edge, the FSM SHALL go to IDLE.
REQ-019 Under reset all counters SHALL be 0, and all outputs (startFrame, startBlock, startStage, setupComplete, metricEn, metricRdAddr, blockCount, frameDone, overrun) SHALL be 0 in the following cycle.
REQ-020 Reset SHALL override frameIn.

Structure
REQ-021 A shared package SHALL hold NUM_STATES, SETUP_WORDS, the FSM state encoding and the metric address width.
REQ-022 The feed counter SHALL be one sub-module, metric_feed_counter (start pulse in; en and addr out).
REQ-023 All outputs SHALL be registered.

Verification
REQ-024 Reset, then frameIn, then 64 setupValid (NUM_STAGES=2) -> setupComplete rises the cycle after the 64th write; the 63rd write leaves the FSM in SETUP.
REQ-025 READY, then blockIn with clkEn -> startBlock and startStage at T+1, metricEn at T+2..T+17 with addr 0..15, then WAIT_DONE.
REQ-026 blockIn during FEED -> overrun=1 and stays 1; metricEn sequence is unaffected; no extra startBlock.
REQ-027 64 full blocks -> blockCount=64, frameDone pulses once, FSM enters IDLE.
REQ-028 frameIn at metricRdAddr=7 -> startFrame pulses, metricEn drops next cycle, blockCount=0, FSM enters SETUP.
REQ-029 resetN low during WAIT_DONE with lastStageDone high -> blockCount stays 0 and all outputs are 0 next cycle.
